// File: rtl/countdown_timer.sv
// Countdown timer: loads a clamped hh:mm:ss:cc preset and decrements it at the tick rate to zero.
// The timer flags expiry with a one-cycle o_done pulse and a sticky o_expired level.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_runstop,
  input  logic       i_clear,
  input  logic [6:0] preset_msec,
  input  logic [5:0] preset_sec,
  input  logic [5:0] preset_min,
  input  logic [4:0] preset_hour,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       o_running,
  output logic       o_done,
  output logic       o_expired
);

  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [6:0]    msec_q, msec_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          done_q, done_d;

  logic tick, is_zero, is_one, load_ok;

  assign tick    = (state_q == RUN) && (tick_q == TICK_LAST);
  assign is_zero = (msec_q == 7'd0) && (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == 5'd0);
  assign is_one  = (msec_q == 7'd1) && (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == 5'd0);
  assign load_ok = i_load && (state_q != RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      msec_q  <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      msec_q  <= msec_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      done_q  <= done_d;
    end
  end

  // Expiry beats a coincident runstop so a zero count never lands in PAUSE.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else if (load_ok) begin
      state_d = IDLE;
    end else if (tick && is_one) begin
      state_d = EXPIRED;
    end else if (i_runstop) begin
      case (state_q)
        IDLE:    state_d = is_zero ? IDLE : RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        EXPIRED: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    msec_d = msec_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    case (state_q)
      RUN:     tick_d = tick ? '0 : tick_q + TW'(1);
      PAUSE:   tick_d = tick_q;
      default: tick_d = '0;
    endcase
    if (i_clear) begin
      tick_d = '0;
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (load_ok) begin
      tick_d = '0;
      msec_d = (preset_msec > 7'd99) ? 7'd99 : preset_msec;
      sec_d  = (preset_sec  > 6'd59) ? 6'd59 : preset_sec;
      min_d  = (preset_min  > 6'd59) ? 6'd59 : preset_min;
      hour_d = (preset_hour > 5'd23) ? 5'd23 : preset_hour;
    end else if (tick) begin
      // Borrow ripples upward only while the lower field is already zero.
      msec_d = (msec_q == 7'd0) ? 7'd99 : msec_q - 7'd1;
      if (msec_q == 7'd0) begin
        sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        if (sec_q == 6'd0) begin
          min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
          if (min_q == 6'd0) begin
            hour_d = hour_q - 5'd1;
          end
        end
      end
    end
  end

  always_comb begin
    done_d    = (state_q == RUN) && (state_d == EXPIRED);
    o_running = (state_q == RUN);
    o_expired = (state_q == EXPIRED);
    o_done    = done_q;
    msec      = msec_q;
    sec       = sec_q;
    min       = min_q;
    hour      = hour_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4; each task drives one scenario and checks inline.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_load = 1'b0, i_runstop = 1'b0, i_clear = 1'b0;
  logic [6:0] preset_msec = '0;
  logic [5:0] preset_sec = '0, preset_min = '0;
  logic [4:0] preset_hour = '0;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       o_running, o_done, o_expired;

  int checks = 0;
  int fails  = 0;

  logic [23:0] cnt_all;
  assign cnt_all = {hour, min, sec, msec};

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .i_load(i_load), .i_runstop(i_runstop), .i_clear(i_clear),
    .preset_msec(preset_msec), .preset_sec(preset_sec), .preset_min(preset_min),
    .preset_hour(preset_hour), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .o_running(o_running), .o_done(o_done), .o_expired(o_expired)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] hms(input int h, input int m, input int s, input int c);
    hms = {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  // Advance past one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input int h, input int m, input int s, input int c);
    preset_hour = 5'(h);
    preset_min  = 6'(m);
    preset_sec  = 6'(s);
    preset_msec = 7'(c);
  endtask

  task automatic pulse_load();
    i_load = 1'b1; step(); i_load = 1'b0;
  endtask

  task automatic pulse_runstop();
    i_runstop = 1'b1; step(); i_runstop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_load    = 1'($urandom_range(0, 1));
      i_runstop = 1'($urandom_range(0, 1));
      i_clear   = 1'($urandom_range(0, 1));
      set_preset(1, 2, 3, 4);
      step();
    end
    i_load = 1'b0; i_runstop = 1'b0; i_clear = 1'b0;
    checks++;
    if (cnt_all !== 24'd0) begin fails++; $display("FAIL reset_count: got %h exp %h", cnt_all, 24'd0); end
    checks++;
    if ({o_running, o_done, o_expired} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b exp 000", {o_running, o_done, o_expired});
    end
    reset = 1'b1;
    step(); step();
    checks++;
    if ({cnt_all, o_running, o_done, o_expired} !== 27'd0) begin
      fails++; $display("FAIL reset_release: got %h exp 0", {cnt_all, o_running, o_done, o_expired});
    end
  endtask

  task automatic test_load_run();
    int t;
    set_preset(0, 0, 1, 2);
    pulse_load();
    checks++;
    if (cnt_all !== hms(0, 0, 1, 2)) begin fails++; $display("FAIL load_value: got %h exp %h", cnt_all, hms(0, 0, 1, 2)); end
    checks++;
    if (o_running !== 1'b0) begin fails++; $display("FAIL load_idle: running got %b exp 0", o_running); end
    pulse_runstop();
    checks++;
    if (o_running !== 1'b1) begin fails++; $display("FAIL run_start: running got %b exp 1", o_running); end
    checks++;
    if (cnt_all !== hms(0, 0, 1, 2)) begin fails++; $display("FAIL run_nodec: got %h exp %h", cnt_all, hms(0, 0, 1, 2)); end
    for (int k = 1; k <= 102; k++) begin
      repeat (4) step();
      t = 102 - k;
      checks++;
      if (cnt_all !== hms(0, 0, t / 100, t % 100)) begin
        fails++; $display("FAIL countdown_%0d: got %h exp %h", k, cnt_all, hms(0, 0, t / 100, t % 100));
      end
      checks++;
      if ({o_running, o_done, o_expired} !== ((k == 102) ? 3'b011 : 3'b100)) begin
        fails++; $display("FAIL countdown_flags_%0d: got %b exp %b", k, {o_running, o_done, o_expired},
                          (k == 102) ? 3'b011 : 3'b100);
      end
    end
    step();
    checks++;
    if ({o_running, o_done, o_expired} !== 3'b001) begin
      fails++; $display("FAIL done_single: got %b exp 001", {o_running, o_done, o_expired});
    end
    repeat (8) step();
    checks++;
    if ({cnt_all, o_expired} !== {24'd0, 1'b1}) begin
      fails++; $display("FAIL expired_hold: got %h exp %h", {cnt_all, o_expired}, {24'd0, 1'b1});
    end
  endtask

  task automatic test_expired_runstop();
    pulse_runstop();
    checks++;
    if ({cnt_all, o_running, o_done, o_expired} !== 27'd0) begin
      fails++; $display("FAIL expired_to_idle: got %h exp 0", {cnt_all, o_running, o_done, o_expired});
    end
    pulse_runstop();
    step();
    checks++;
    if (o_running !== 1'b0) begin fails++; $display("FAIL idle_zero_runstop: running got %b exp 0", o_running); end
  endtask

  task automatic test_clamp();
    set_preset(31, 63, 63, 120);
    pulse_load();
    checks++;
    if (cnt_all !== hms(23, 59, 59, 99)) begin fails++; $display("FAIL clamp: got %h exp %h", cnt_all, hms(23, 59, 59, 99)); end
    set_preset(1, 0, 0, 0);
    pulse_load();
    pulse_runstop();
    repeat (4) step();
    checks++;
    if (cnt_all !== hms(0, 59, 59, 99)) begin fails++; $display("FAIL hour_borrow: got %h exp %h", cnt_all, hms(0, 59, 59, 99)); end
    checks++;
    if (o_running !== 1'b1) begin fails++; $display("FAIL borrow_running: got %b exp 1", o_running); end
  endtask

  // Enters with the tick counter just wrapped to 0 at 00:59:59:99.
  task automatic test_pause_resume();
    step();
    pulse_runstop();
    checks++;
    if ({cnt_all, o_running} !== {hms(0, 59, 59, 99), 1'b0}) begin
      fails++; $display("FAIL pause_enter: got %h exp %h", {cnt_all, o_running}, {hms(0, 59, 59, 99), 1'b0});
    end
    repeat (20) step();
    checks++;
    if (cnt_all !== hms(0, 59, 59, 99)) begin fails++; $display("FAIL pause_frozen: got %h exp %h", cnt_all, hms(0, 59, 59, 99)); end
    pulse_runstop();
    checks++;
    if ({cnt_all, o_running} !== {hms(0, 59, 59, 99), 1'b1}) begin
      fails++; $display("FAIL resume: got %h exp %h", {cnt_all, o_running}, {hms(0, 59, 59, 99), 1'b1});
    end
    step();
    checks++;
    if (cnt_all !== hms(0, 59, 59, 99)) begin fails++; $display("FAIL resume_early: got %h exp %h", cnt_all, hms(0, 59, 59, 99)); end
    step();
    checks++;
    if (cnt_all !== hms(0, 59, 59, 98)) begin fails++; $display("FAIL resume_phase: got %h exp %h", cnt_all, hms(0, 59, 59, 98)); end
  endtask

  task automatic test_priority();
    set_preset(0, 0, 0, 5);
    pulse_load();
    checks++;
    if ({cnt_all, o_running} !== {hms(0, 59, 59, 98), 1'b1}) begin
      fails++; $display("FAIL load_in_run: got %h exp %h", {cnt_all, o_running}, {hms(0, 59, 59, 98), 1'b1});
    end
    i_clear = 1'b1; i_load = 1'b1;
    step();
    i_clear = 1'b0; i_load = 1'b0;
    checks++;
    if ({cnt_all, o_running, o_done, o_expired} !== 27'd0) begin
      fails++; $display("FAIL clear_load: got %h exp 0", {cnt_all, o_running, o_done, o_expired});
    end
    pulse_runstop();
    checks++;
    if (o_running !== 1'b0) begin fails++; $display("FAIL clear_then_runstop: running got %b exp 0", o_running); end
  endtask

  task automatic test_reset_mid_run();
    set_preset(0, 0, 0, 50);
    pulse_load();
    pulse_runstop();
    step(); step();
    checks++;
    if ({cnt_all, o_running} !== {hms(0, 0, 0, 50), 1'b1}) begin
      fails++; $display("FAIL pre_reset: got %h exp %h", {cnt_all, o_running}, {hms(0, 0, 0, 50), 1'b1});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({cnt_all, o_running, o_done, o_expired} !== 27'd0) begin
      fails++; $display("FAIL reset_mid_run: got %h exp 0", {cnt_all, o_running, o_done, o_expired});
    end
    reset = 1'b1;
    repeat (6) step();
    checks++;
    if ({cnt_all, o_running, o_done, o_expired} !== 27'd0) begin
      fails++; $display("FAIL after_reset_idle: got %h exp 0", {cnt_all, o_running, o_done, o_expired});
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_expired_runstop();
    test_clamp();
    test_pause_resume();
    test_priority();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
